// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32 immediate decoder feeding a 2-entry skid FIFO.
// Optional Z-immediate (CSR uimm) decode is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_instr,
  output logic [1:0]      occupancy
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            wr_ptr, rd_ptr;
  logic            push, pop;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] imm_mem   [2];
  logic [2:0]      fmt_mem   [2];
  logic [31:0]     instr_mem [2];

  // Fill with the sign first, then overwrite the low field; this reaches XLEN for any width.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt       = FMT_I;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = in_instr[31:20];
      end
      7'b0100011: begin
        dec_fmt       = FMT_S;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt       = FMT_B;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt       = FMT_U;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[31:0] = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt       = FMT_J;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
`ifdef IMM_GEN_ZIMM_EN
      7'b1110011: begin
        if (in_instr[14]) begin
          dec_fmt      = FMT_Z;
          dec_imm[4:0] = in_instr[19:15];
        end
      end
`endif
      default: begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
  end

  // Ready depends only on held state and reset, never on out_ready.
  assign in_ready  = !rst && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = state;
  assign out_imm   = imm_mem[rd_ptr];
  assign out_fmt   = fmt_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      imm_mem[0]   <= '0;
      imm_mem[1]   <= '0;
      fmt_mem[0]   <= FMT_NONE;
      fmt_mem[1]   <= FMT_NONE;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        imm_mem[wr_ptr]   <= dec_imm;
        fmt_mem[wr_ptr]   <= dec_fmt;
        instr_mem[wr_ptr] <= in_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe at XLEN 32 and 64.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] out_imm;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt, out_fmt64;
  logic [31:0] out_instr, out_instr64;
  logic [1:0]  occupancy, occupancy64;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_instr(out_instr), .occupancy(occupancy)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_instr(out_instr64), .occupancy(occupancy64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode: immediates as signed integers widened to 64 bits.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e.instr = w;
    e.fmt   = 3'd0;
    e.imm   = 64'd0;
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e.fmt = 3'd1; e.imm = longint'($signed(w[31:20]));
      end
      7'b0100011: begin
        e.fmt = 3'd2; e.imm = longint'($signed({w[31:25], w[11:7]}));
      end
      7'b1100011: begin
        e.fmt = 3'd3; e.imm = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4; e.imm = longint'($signed({w[31:12], 12'h000}));
      end
      7'b1101111: begin
        e.fmt = 3'd5; e.imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      end
`ifdef IMM_GEN_ZIMM_EN
      7'b1110011: if (w[14]) begin
        e.fmt = 3'd6; e.imm = 64'(w[19:15]);
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // One stimulus cycle; the expected entry is queued when the model says the word is taken.
  task automatic cycle(input logic v, input logic [31:0] w, input logic rdy);
    bit can_push;
    @(negedge clk);
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
    can_push  = (sb.size() < 2) && !rst;
    #2;
    if (v && can_push) sb.push_back(model(w));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready), 64'd0);
    chk({tag, "_out_imm"},   64'(out_imm), 64'd0);
    chk({tag, "_out_fmt"},   64'(out_fmt), 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    chk({tag, "_out_imm64"}, out_imm64, 64'd0);
  endtask

  // Reset asserted in the middle of the low phase, held across one rising edge.
  task automatic pulse_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    sb.delete();
    @(negedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: checks handshake state and the head entry every cycle, pops on acceptance.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        chk("occupancy64", 64'(occupancy64), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        if (out_valid) begin
          if (sb.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL sb_underflow: out_valid=1 with nothing expected");
          end else begin
            h = sb[0];
            chk("out_imm32", 64'(out_imm), 64'(h.imm[31:0]));
            chk("out_imm64", out_imm64, h.imm);
            chk("out_fmt", 64'(out_fmt), 64'(h.fmt));
            chk("out_fmt64", 64'(out_fmt64), 64'(h.fmt));
            chk("out_instr", 64'(out_instr), 64'(h.instr));
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  logic [6:0] ops [11] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011,
                           7'b1111111};

  initial begin
    logic [31:0] w;
    #1 rst = 1'b1;
    #2 chk_reset_outputs("power_on");
    @(negedge clk);
    #3 rst = 1'b0;

    cycle(1'b1, 32'hFFF00093, 1'b1);
    cycle(1'b1, 32'h800002B7, 1'b1);
    cycle(1'b1, 32'hFE000EE3, 1'b1);
    cycle(1'b1, 32'h00FAD073, 1'b1);
    cycle(1'b1, 32'h00FA9073, 1'b1);
    cycle(1'b1, 32'h0000007F, 1'b1);
    cycle(1'b1, 32'h8000006F, 1'b1);
    cycle(1'b1, 32'hFE112E23, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    // Stall: third back-to-back word must be refused, first two drain in order.
    cycle(1'b1, 32'h00100093, 1'b0);
    cycle(1'b1, 32'h00200113, 1'b0);
    cycle(1'b1, 32'h00300193, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);

    // Steady occupancy of one with simultaneous push and pop.
    cycle(1'b1, 32'h12345037, 1'b0);
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      w[6:0] = ops[i];
      cycle(1'b1, w, 1'b1);
    end
    repeat (2) cycle(1'b0, 32'h0, 1'b1);

    // Full FIFO discarded by reset, then first accept after release.
    cycle(1'b1, 32'hABCDE0B7, 1'b0);
    cycle(1'b1, 32'h7FF00013, 1'b0);
    pulse_reset();
    cycle(1'b1, 32'h00FAD073, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 10)];
      cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0));
    end

    repeat (6) cycle(1'b0, 32'h0, 1'b1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
